excp_commit_arbiter: RTL and testbench
======================================

Name: excp_commit_arbiter

Overview:
- Multi-lane successor of the single-lane exception classifier.
- Sits at the commit stage and takes LANES already-classified exception records, plus the interrupt-pending flag and ERTN requests.
- Selects the oldest trapping event and latches its CSR update record.
- Runs a flush/redirect handshake with the frontend, then a drain window, before accepting new commits.

Parameters:
- LANES, 2, number of commit lanes; lane 0 is the oldest; range 1..4.
- DRAIN_CYCLES, 2, idle cycles held after redirect acceptance; range 0..15.
- IDXW, $clog2(LANES) with a minimum of 1, width of the lane index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- lane_valid_i  in  LANES  lane carries a committing instruction.
- lane_excp_i  in  LANES  lane instruction raised an exception.
- lane_ertn_i  in  LANES  lane instruction is ERTN.
- lane_ecode_i  in  LANES*6  per-lane ecode.
- lane_esubcode_i  in  LANES*9  per-lane esubcode.
- lane_pc_i  in  LANES*32  per-lane PC.
- lane_badva_i  in  LANES*32  per-lane bad VA.
- lane_va_error_i  in  LANES  BADV write request.
- lane_tlbrefill_i  in  LANES  TLB refill class.
- lane_tlbehi_i  in  LANES  TLBEHI update request.
- int_pending_i  in  1  enabled interrupt is pending.
- eentry_i  in  32  general exception entry.
- tlbrentry_i  in  32  TLB refill entry.
- era_i  in  32  ERA value, used by ERTN.
- in_ready_o  out  1  commit stage may advance.
- commit_mask_o  out  LANES  lanes retiring this cycle (combinational).
- csr_excp_we_o  out  1  one-cycle pulse: write ESTAT/ERA/BADV/TLBEHI.
- csr_ertn_o  out  1  one-cycle pulse: restore PLV/IE.
- ecode_o  out  6  latched ecode.
- esubcode_o  out  9  latched esubcode.
- era_o  out  32  latched PC of the trapping lane.
- badva_o  out  32  latched bad VA.
- va_error_o  out  1  latched flag.
- tlbrefill_o  out  1  latched flag.
- tlbehi_update_o  out  1  latched flag.
- excp_lane_o  out  IDXW  latched lane index.
- flush_o  out  1  pipeline flush.
- redirect_valid_o  out  1  redirect request to the frontend.
- redirect_pc_o  out  32  redirect target.
- redirect_ready_i  in  1  frontend accepts the redirect.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All registered outputs are 0.
  - in_ready_o = 1.
  - Asserting rst mid-operation aborts everything; no redirect or CSR pulse follows release.
- Event per lane i (valid only when lane_valid_i[i]):
  - Interrupt: lane i is the lowest-index valid lane and int_pending_i = 1.
  - Otherwise exception: lane_excp_i[i] = 1.
  - Otherwise ERTN: lane_ertn_i[i] = 1.
- Selection:
  - The lowest-index lane with an event wins.
  - Interrupt beats that lane's own exception: ecode 0, esubcode 0, all flags 0, badva = pc.
  - int_pending_i with no valid lane is ignored.
  - Any lane with an exception also beats a younger lane's ERTN.
- commit_mask_o, in IDLE:
  - Bit j = lane_valid_i[j] for all j below the winner.
  - The winning lane is included only for ERTN.
  - All valid lanes commit if there is no event.
  - All zero outside IDLE.
- FSM:
  - IDLE: an event is accepted in the same cycle. Record fields are latched, plus redirect_pc_o. The target is tlbrentry_i if tlbrefill, era_i if ERTN, else eentry_i. Go to COMMIT.
  - COMMIT (1 cycle): pulse csr_excp_we_o for exceptions/interrupts, or csr_ertn_o for ERTN. flush_o = 1. Go to REDIRECT.
  - REDIRECT: flush_o = 1, redirect_valid_o = 1, and both stay stable until redirect_ready_i = 1. On that handshake, go to DRAIN with the counter at DRAIN_CYCLES; if DRAIN_CYCLES = 0, go to IDLE.
  - DRAIN: the counter decrements each cycle; at 1, go to IDLE.
- in_ready_o = 1 only in IDLE.
- Latency: event cycle E; csr pulse at E+1; redirect_valid_o first high at E+2.
- Latched outputs hold until the next event; they are not cleared on return to IDLE.
- The counter is 4 bits and never underflows.
- redirect_ready_i is ignored outside REDIRECT.
- Lane inputs are don't-care outside IDLE.

Test Plan:
- Reset, then lanes {0,1} valid, no events → commit_mask_o = 2'b11, in_ready_o = 1, no pulses.
- Lane1 exception (ecode 0x0B, pc 0x1C000010), lane0 clean, eentry 0x1C008000, redirect_ready_i = 1 at E+4:
  - E: mask = 2'b01, excp_lane_o = 1.
  - E+1: csr_excp_we_o pulse, ecode_o = 0x0B, era_o = 0x1C000010.
  - E+2..E+4: redirect_pc_o = 0x1C008000.
  - E+7: back in IDLE.
- Lane0 TLB refill (tlbrefill = 1, badva 0x00400000, tlbrentry 0x1C00F000) with lane1 also excepting → lane 0 chosen, redirect_pc_o = 0x1C00F000, badva_o = 0x00400000, tlbehi_update_o = 1, mask = 0.
- int_pending_i = 1 with lane0 excepting (ecode 0x08) → ecode_o = 0, era_o = lane0 pc.
- int_pending_i = 1 with no valid lanes → ignored, state stays IDLE.
- Lane0 ERTN (era_i 0x1C000200) with lane1 excepting → mask = 2'b01, csr_ertn_o pulse, no csr_excp_we_o, redirect_pc_o = 0x1C000200.
- rst asserted while in REDIRECT → next cycle all outputs 0, in_ready_o = 1; after release no redirect or CSR pulse.

Source files
------------

// File: rtl/excp_commit_arbiter.sv
// Commit-stage exception arbiter. It picks the oldest trapping lane, latches that lane's CSR record,
// and then sequences the flush, the frontend redirect handshake and a drain window.
//
// state     | meaning
// S_IDLE    | accepting commits; an event is taken in the same cycle
// S_COMMIT  | one cycle: CSR write / ERTN pulse, flush asserted
// S_REDIRECT| flush + redirect_valid held until redirect_ready_i
// S_DRAIN   | idle countdown before commits resume
module excp_commit_arbiter #(
   parameter int LANES        = 2,
   parameter int DRAIN_CYCLES = 2,
   parameter int IDXW         = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [LANES-1:0]    lane_valid_i,
   input  logic [LANES-1:0]    lane_excp_i,
   input  logic [LANES-1:0]    lane_ertn_i,
   input  logic [LANES*6-1:0]  lane_ecode_i,
   input  logic [LANES*9-1:0]  lane_esubcode_i,
   input  logic [LANES*32-1:0] lane_pc_i,
   input  logic [LANES*32-1:0] lane_badva_i,
   input  logic [LANES-1:0]    lane_va_error_i,
   input  logic [LANES-1:0]    lane_tlbrefill_i,
   input  logic [LANES-1:0]    lane_tlbehi_i,
   input  logic                int_pending_i,
   input  logic [31:0]         eentry_i,
   input  logic [31:0]         tlbrentry_i,
   input  logic [31:0]         era_i,
   output logic                in_ready_o,
   output logic [LANES-1:0]    commit_mask_o,
   output logic                csr_excp_we_o,
   output logic                csr_ertn_o,
   output logic [5:0]          ecode_o,
   output logic [8:0]          esubcode_o,
   output logic [31:0]         era_o,
   output logic [31:0]         badva_o,
   output logic                va_error_o,
   output logic                tlbrefill_o,
   output logic                tlbehi_update_o,
   output logic [IDXW-1:0]     excp_lane_o,
   output logic                flush_o,
   output logic                redirect_valid_o,
   output logic [31:0]         redirect_pc_o,
   input  logic                redirect_ready_i
);

   typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_REDIRECT, S_DRAIN} state_t;

   logic [5:0]  ecode_a    [LANES];
   logic [8:0]  esubcode_a [LANES];
   logic [31:0] pc_a       [LANES];
   logic [31:0] badva_a    [LANES];

   for (genvar g = 0; g < LANES; g++) begin : g_unpack
      assign ecode_a[g]    = lane_ecode_i[g*6 +: 6];
      assign esubcode_a[g] = lane_esubcode_i[g*9 +: 9];
      assign pc_a[g]       = lane_pc_i[g*32 +: 32];
      assign badva_a[g]    = lane_badva_i[g*32 +: 32];
   end

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              csr_excp_we_q, csr_excp_we_d, csr_ertn_q, csr_ertn_d;
   logic              flush_q, flush_d, redirect_valid_q, redirect_valid_d;
   logic [5:0]        ecode_q, ecode_d;
   logic [8:0]        esubcode_q, esubcode_d;
   logic [31:0]       era_q, era_d, badva_q, badva_d, redirect_pc_q, redirect_pc_d;
   logic              va_error_q, va_error_d, tlbrefill_q, tlbrefill_d, tlbehi_q, tlbehi_d;
   logic [IDXW-1:0]   excp_lane_q, excp_lane_d;

   logic              any_valid, ev_found, win_int, win_excp, win_ertn;
   logic [IDXW-1:0]   first_v, win;
   logic [LANES-1:0]  mask;

   // Interrupts attach to the oldest valid lane, so when one is pending that lane always wins.
   always_comb begin
      any_valid = 1'b0;
      first_v   = '0;
      for (int i = LANES-1; i >= 0; i--) begin
         if (lane_valid_i[i]) begin
            any_valid = 1'b1;
            first_v   = IDXW'(i);
         end
      end
      ev_found = 1'b0;
      win      = '0;
      for (int i = LANES-1; i >= 0; i--) begin
         if (lane_valid_i[i] && ((int_pending_i && first_v == IDXW'(i)) ||
                                 lane_excp_i[i] || lane_ertn_i[i])) begin
            ev_found = 1'b1;
            win      = IDXW'(i);
         end
      end
      win_int  = int_pending_i && any_valid;
      win_excp = ev_found && !win_int && lane_excp_i[win];
      win_ertn = ev_found && !win_int && !lane_excp_i[win] && lane_ertn_i[win];
      mask     = '0;
      for (int j = 0; j < LANES; j++) begin
         if (!ev_found || IDXW'(j) < win)
            mask[j] = lane_valid_i[j];
         else if (IDXW'(j) == win && win_ertn)
            mask[j] = 1'b1;
      end
   end

   assign in_ready_o    = (state_q == S_IDLE);
   assign commit_mask_o = (state_q == S_IDLE) ? mask : '0;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      ecode_d       = ecode_q;
      esubcode_d    = esubcode_q;
      era_d         = era_q;
      badva_d       = badva_q;
      va_error_d    = va_error_q;
      tlbrefill_d   = tlbrefill_q;
      tlbehi_d      = tlbehi_q;
      excp_lane_d   = excp_lane_q;
      redirect_pc_d = redirect_pc_q;
      csr_excp_we_d = 1'b0;
      csr_ertn_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (ev_found) begin
               state_d       = S_COMMIT;
               ecode_d       = win_int ? 6'd0 : ecode_a[win];
               esubcode_d    = win_int ? 9'd0 : esubcode_a[win];
               era_d         = pc_a[win];
               badva_d       = win_int ? pc_a[win] : badva_a[win];
               va_error_d    = win_excp && lane_va_error_i[win];
               tlbrefill_d   = win_excp && lane_tlbrefill_i[win];
               tlbehi_d      = win_excp && lane_tlbehi_i[win];
               excp_lane_d   = win;
               csr_excp_we_d = !win_ertn;
               csr_ertn_d    = win_ertn;
               if (win_excp && lane_tlbrefill_i[win]) redirect_pc_d = tlbrentry_i;
               else if (win_ertn)                     redirect_pc_d = era_i;
               else                                   redirect_pc_d = eentry_i;
            end
         end
         S_COMMIT: state_d = S_REDIRECT;
         S_REDIRECT: begin
            if (redirect_ready_i) begin
               state_d = (DRAIN_CYCLES == 0) ? S_IDLE : S_DRAIN;
               cnt_d   = 4'(DRAIN_CYCLES);
            end
         end
         S_DRAIN: begin
            if (cnt_q <= 4'd1) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      flush_d          = (state_d == S_COMMIT) || (state_d == S_REDIRECT);
      redirect_valid_d = (state_d == S_REDIRECT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= S_IDLE;
         cnt_q            <= '0;
         csr_excp_we_q    <= 1'b0;
         csr_ertn_q       <= 1'b0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         ecode_q          <= '0;
         esubcode_q       <= '0;
         era_q            <= '0;
         badva_q          <= '0;
         va_error_q       <= 1'b0;
         tlbrefill_q      <= 1'b0;
         tlbehi_q         <= 1'b0;
         excp_lane_q      <= '0;
         redirect_pc_q    <= '0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         csr_excp_we_q    <= csr_excp_we_d;
         csr_ertn_q       <= csr_ertn_d;
         flush_q          <= flush_d;
         redirect_valid_q <= redirect_valid_d;
         ecode_q          <= ecode_d;
         esubcode_q       <= esubcode_d;
         era_q            <= era_d;
         badva_q          <= badva_d;
         va_error_q       <= va_error_d;
         tlbrefill_q      <= tlbrefill_d;
         tlbehi_q         <= tlbehi_d;
         excp_lane_q      <= excp_lane_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign csr_excp_we_o    = csr_excp_we_q;
   assign csr_ertn_o       = csr_ertn_q;
   assign flush_o          = flush_q;
   assign redirect_valid_o = redirect_valid_q;
   assign ecode_o          = ecode_q;
   assign esubcode_o       = esubcode_q;
   assign era_o            = era_q;
   assign badva_o          = badva_q;
   assign va_error_o       = va_error_q;
   assign tlbrefill_o      = tlbrefill_q;
   assign tlbehi_update_o  = tlbehi_q;
   assign excp_lane_o      = excp_lane_q;
   assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_excp_commit_arbiter.sv
// Directed bench for excp_commit_arbiter (LANES=2, DRAIN_CYCLES=2): a vector table for lane
// selection and commit masks, plus hand-written sequences for timing, reset abort and latching.
module tb_excp_commit_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  lane_valid_i, lane_excp_i, lane_ertn_i;
   logic [11:0] lane_ecode_i;
   logic [17:0] lane_esubcode_i;
   logic [63:0] lane_pc_i, lane_badva_i;
   logic [1:0]  lane_va_error_i, lane_tlbrefill_i, lane_tlbehi_i;
   logic        int_pending_i;
   logic [31:0] eentry_i, tlbrentry_i, era_i;
   logic        in_ready_o;
   logic [1:0]  commit_mask_o;
   logic        csr_excp_we_o, csr_ertn_o;
   logic [5:0]  ecode_o;
   logic [8:0]  esubcode_o;
   logic [31:0] era_o, badva_o, redirect_pc_o;
   logic        va_error_o, tlbrefill_o, tlbehi_update_o;
   logic [0:0]  excp_lane_o;
   logic        flush_o, redirect_valid_o, redirect_ready_i;

   int total = 0;
   int passed = 0;

   excp_commit_arbiter #(.LANES(2), .DRAIN_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .lane_valid_i(lane_valid_i), .lane_excp_i(lane_excp_i), .lane_ertn_i(lane_ertn_i),
      .lane_ecode_i(lane_ecode_i), .lane_esubcode_i(lane_esubcode_i),
      .lane_pc_i(lane_pc_i), .lane_badva_i(lane_badva_i),
      .lane_va_error_i(lane_va_error_i), .lane_tlbrefill_i(lane_tlbrefill_i),
      .lane_tlbehi_i(lane_tlbehi_i), .int_pending_i(int_pending_i),
      .eentry_i(eentry_i), .tlbrentry_i(tlbrentry_i), .era_i(era_i),
      .in_ready_o(in_ready_o), .commit_mask_o(commit_mask_o),
      .csr_excp_we_o(csr_excp_we_o), .csr_ertn_o(csr_ertn_o),
      .ecode_o(ecode_o), .esubcode_o(esubcode_o), .era_o(era_o), .badva_o(badva_o),
      .va_error_o(va_error_o), .tlbrefill_o(tlbrefill_o), .tlbehi_update_o(tlbehi_update_o),
      .excp_lane_o(excp_lane_o), .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
      .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] v, e, r;
      logic       ip;
      logic [1:0] mask;
      logic       ev;
      logic       lane;
      logic       ertn;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_lanes();
      lane_valid_i = '0; lane_excp_i = '0; lane_ertn_i = '0;
      lane_ecode_i = '0; lane_esubcode_i = '0; lane_pc_i = '0; lane_badva_i = '0;
      lane_va_error_i = '0; lane_tlbrefill_i = '0; lane_tlbehi_i = '0;
      int_pending_i = 1'b0;
   endtask

   // Complete the redirect handshake and wait, bounded, for the return to IDLE.
   task automatic finish_txn();
      int n = 0;
      redirect_ready_i = 1'b1;
      while (!in_ready_o && n < 20) begin
         tick();
         n++;
      end
      redirect_ready_i = 1'b0;
      chk("return_to_idle", in_ready_o, 1);
   endtask

   vec_t tbl[13];

   initial begin
      int pulses;
      tbl[0]  = '{2'b11, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{2'b01, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{2'b11, 2'b10, 2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{2'b11, 2'b01, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{2'b11, 2'b10, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{2'b11, 2'b00, 2'b10, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1};
      tbl[8]  = '{2'b10, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{2'b01, 2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{2'b11, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{2'b11, 2'b00, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0};

      rst = 1'b1;
      clear_lanes();
      redirect_ready_i = 1'b0;
      eentry_i = 32'h1C00_8000; tlbrentry_i = 32'h1C00_F000; era_i = 32'h1C00_0200;
      #1;
      chk("reset_in_ready", in_ready_o, 1);
      chk("reset_outputs", {csr_excp_we_o, csr_ertn_o, flush_o, redirect_valid_o, ecode_o, excp_lane_o}, 0);
      chk("reset_redirect_pc", redirect_pc_o, 0);
      tick(); tick();
      rst = 1'b0;
      tick();

      for (int k = 0; k < 13; k++) begin
         lane_valid_i = tbl[k].v; lane_excp_i = tbl[k].e; lane_ertn_i = tbl[k].r;
         int_pending_i = tbl[k].ip;
         #1;
         chk($sformatf("vec%0d_mask", k), commit_mask_o, tbl[k].mask);
         chk($sformatf("vec%0d_ready", k), in_ready_o, 1);
         tick();
         clear_lanes();
         chk($sformatf("vec%0d_taken", k), in_ready_o, !tbl[k].ev);
         if (tbl[k].ev) begin
            chk($sformatf("vec%0d_lane", k), excp_lane_o, tbl[k].lane);
            chk($sformatf("vec%0d_excp_we", k), csr_excp_we_o, !tbl[k].ertn);
            chk($sformatf("vec%0d_ertn", k), csr_ertn_o, tbl[k].ertn);
            finish_txn();
         end else begin
            chk($sformatf("vec%0d_no_pulse", k), {csr_excp_we_o, csr_ertn_o, flush_o}, 0);
         end
      end

      // Lane 1 exception: full latency and drain timing
      lane_valid_i = 2'b11; lane_excp_i = 2'b10;
      lane_ecode_i = {6'h0B, 6'h00}; lane_pc_i = {32'h1C00_0010, 32'h1C00_000C};
      #1;
      chk("seqA_mask", commit_mask_o, 2'b01);
      tick();                       // E+1
      clear_lanes();
      chk("seqA_excp_we", csr_excp_we_o, 1);
      chk("seqA_ecode", ecode_o, 6'h0B);
      chk("seqA_era", era_o, 32'h1C00_0010);
      chk("seqA_lane", excp_lane_o, 1);
      chk("seqA_flush_commit", {flush_o, redirect_valid_o}, 2'b10);
      tick();                       // E+2
      chk("seqA_pulse_once", csr_excp_we_o, 0);
      chk("seqA_rv_e2", {flush_o, redirect_valid_o}, 2'b11);
      chk("seqA_rpc_e2", redirect_pc_o, 32'h1C00_8000);
      tick();                       // E+3
      chk("seqA_rv_e3", redirect_valid_o, 1);
      tick();                       // E+4
      chk("seqA_rv_e4", redirect_valid_o, 1);
      chk("seqA_rpc_e4", redirect_pc_o, 32'h1C00_8000);
      redirect_ready_i = 1'b1;
      tick();                       // E+5
      redirect_ready_i = 1'b0;
      chk("seqA_drain_e5", {in_ready_o, flush_o, redirect_valid_o}, 0);
      tick();                       // E+6
      chk("seqA_drain_e6", in_ready_o, 0);
      tick();                       // E+7
      chk("seqA_idle_e7", in_ready_o, 1);
      chk("seqA_held_ecode", ecode_o, 6'h0B);

      // Lane 0 TLB refill beats lane 1 exception
      lane_valid_i = 2'b11; lane_excp_i = 2'b11;
      lane_tlbrefill_i = 2'b01; lane_tlbehi_i = 2'b01; lane_va_error_i = 2'b01;
      lane_badva_i = {32'h0000_1234, 32'h0040_0000};
      #1;
      chk("seqB_mask", commit_mask_o, 2'b00);
      tick();
      clear_lanes();
      chk("seqB_lane", excp_lane_o, 0);
      chk("seqB_badva", badva_o, 32'h0040_0000);
      chk("seqB_flags", {va_error_o, tlbrefill_o, tlbehi_update_o}, 3'b111);
      tick();
      chk("seqB_rpc", redirect_pc_o, 32'h1C00_F000);
      finish_txn();

      // Interrupt overrides lane 0's own exception
      lane_valid_i = 2'b01; lane_excp_i = 2'b01; int_pending_i = 1'b1;
      lane_ecode_i = {6'h00, 6'h08}; lane_pc_i = {32'h0, 32'h1C00_0100};
      lane_badva_i = {32'h0, 32'hDEAD_0000}; lane_tlbrefill_i = 2'b01;
      tick();
      clear_lanes();
      chk("seqC_ecode", ecode_o, 0);
      chk("seqC_era", era_o, 32'h1C00_0100);
      chk("seqC_badva", badva_o, 32'h1C00_0100);
      chk("seqC_flags", {va_error_o, tlbrefill_o, tlbehi_update_o}, 0);
      tick();
      chk("seqC_rpc", redirect_pc_o, 32'h1C00_8000);
      finish_txn();

      // Interrupt with no valid lane is ignored
      int_pending_i = 1'b1;
      tick();
      chk("seqD_idle", in_ready_o, 1);
      tick();
      chk("seqD_no_pulse", {csr_excp_we_o, csr_ertn_o, flush_o, redirect_valid_o}, 0);
      clear_lanes();

      // ERTN on lane 0 with lane 1 excepting
      lane_valid_i = 2'b11; lane_ertn_i = 2'b01; lane_excp_i = 2'b10;
      #1;
      chk("seqE_mask", commit_mask_o, 2'b01);
      tick();
      clear_lanes();
      chk("seqE_pulses", {csr_ertn_o, csr_excp_we_o}, 2'b10);
      tick();
      chk("seqE_rpc", redirect_pc_o, 32'h1C00_0200);
      finish_txn();

      // Reset while in REDIRECT aborts everything
      lane_valid_i = 2'b01; lane_excp_i = 2'b01; lane_ecode_i = {6'h00, 6'h05};
      tick();
      clear_lanes();
      tick();
      chk("seqF_in_redirect", redirect_valid_o, 1);
      rst = 1'b1;
      #1;
      chk("seqF_rst_outputs", {csr_excp_we_o, csr_ertn_o, flush_o, redirect_valid_o, ecode_o}, 0);
      chk("seqF_rst_ready", in_ready_o, 1);
      tick();
      rst = 1'b0;
      redirect_ready_i = 1'b1;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (redirect_valid_o || csr_excp_we_o || csr_ertn_o || flush_o) pulses++;
      end
      redirect_ready_i = 1'b0;
      chk("seqF_no_activity", pulses, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
